// File: rtl/xor_parity_arb.sv
// Round-robin arbiter feeding one bit-serial XOR accumulator shared by NREQ requesters.
// Each granted word is folded LSB-first into a parity bit returned over valid/ready.
module xor_parity_arb #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDW   = 2
) (
    input  logic                  ck,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] data,
    input  logic [NREQ-1:0]       odd,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic                  res_parity,
    output logic [IDW-1:0]        res_id
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic             acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             found;
    logic [IDW-1:0]   win;
    logic [IDW-1:0]   cand;
    logic [WIDTH-1:0] sel_word;
    logic             sel_odd;

    // Search starts just after the last served requester and wraps.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = IDW'((32'(ptr_q) + i) % NREQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        sel_word = '0;
        sel_odd  = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (win == IDW'(k)) begin
                sel_word = data[k*WIDTH +: WIDTH];
                sel_odd  = odd[k];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        sreg_d  = sreg_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        gnt     = '0;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    gnt[win] = 1'b1;
                    sreg_d   = sel_word;
                    acc_d    = sel_odd;
                    id_d     = win;
                    cnt_d    = '0;
                    state_d  = StShift;
                end
            end
            StShift: begin
                acc_d  = acc_q ^ sreg_q[0];
                sreg_d = sreg_q >> 1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (res_ready) begin
                    ptr_d   = id_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy       = (state_q != StIdle);
    assign res_valid  = (state_q == StDone);
    assign res_parity = res_valid & acc_q;
    assign res_id     = res_valid ? id_q : '0;

    always_ff @(posedge ck) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= IDW'(NREQ - 1);
            id_q    <= '0;
            sreg_q  <= '0;
            acc_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            sreg_q  <= sreg_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_xor_parity_arb.sv
// Directed bench for xor_parity_arb: reset, latency, round-robin order, odd mode,
// backpressure, mid-operation reset and a randomised run against a round-robin model.
module tb_xor_parity_arb;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 2;

    logic                  ck = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] data;
    logic [NREQ-1:0]       odd;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic                  res_valid;
    logic                  res_ready;
    logic                  res_parity;
    logic [IDW-1:0]        res_id;

    int checks   = 0;
    int failures = 0;

    xor_parity_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .ck(ck), .rst(rst), .req(req), .data(data), .odd(odd), .gnt(gnt), .busy(busy),
        .res_valid(res_valid), .res_ready(res_ready), .res_parity(res_parity), .res_id(res_id)
    );

    always #5 ck = ~ck;

    task automatic step();
        @(posedge ck);
        @(negedge ck);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; data = '0; odd = '0; res_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    function automatic int rr_pick(input logic [3:0] r, input int p);
        for (int i = 1; i <= 4; i++) if (r[(p + i) % 4]) return (p + i) % 4;
        return 0;
    endfunction

    task automatic test_reset();
        rst = 1'b1; req = '0; data = '0; odd = '0; res_ready = 1'b0;
        step();
        step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", res_valid); end
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        checks++; if (res_parity !== 1'b0) begin failures++; $display("FAIL reset_parity got=%b exp=0", res_parity); end
        checks++; if (res_id !== 2'd0) begin failures++; $display("FAIL reset_id got=%0d exp=0", res_id); end
        rst = 1'b0;
        #1;
    endtask

    task automatic test_single();
        req = 4'b0001; data[7:0] = 8'hA5; odd = '0; res_ready = 1'b1;
        #1;
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL single_gnt got=%b exp=0001", gnt); end
        step();
        req = '0;
        for (int k = 1; k <= WIDTH; k++) begin
            checks++;
            if (res_valid !== 1'b0 || gnt !== 4'b0000) begin
                failures++; $display("FAIL single_early cyc=%0d valid=%b gnt=%b exp valid=0 gnt=0", k, res_valid, gnt);
            end
            if (k < WIDTH) step();
        end
        step();
        checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL single_latency valid=%b exp=1", res_valid); end
        checks++; if (res_parity !== 1'b0) begin failures++; $display("FAIL single_parity got=%b exp=0", res_parity); end
        checks++; if (res_id !== 2'd0) begin failures++; $display("FAIL single_id got=%0d exp=0", res_id); end
        step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle busy=%b exp=0", busy); end
    endtask

    task automatic test_all_req();
        logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [3:0] log_g [8];
        int         log_c [8];
        int         ng = 0;
        int         nv = 0;
        do_reset();
        res_ready = 1'b1;
        req = 4'b1111;
        for (int k = 0; k < NREQ; k++) data[k*WIDTH +: WIDTH] = 8'h01;
        #1;
        for (int cyc = 0; cyc <= 40; cyc++) begin
            if (gnt !== 4'b0000 && ng < 8) begin log_g[ng] = gnt; log_c[ng] = cyc; ng++; end
            if (res_valid === 1'b1) begin
                checks++;
                if (res_parity !== 1'b1 || res_id !== IDW'(nv % 4)) begin
                    failures++; $display("FAIL rr_result n=%0d par=%b id=%0d exp par=1 id=%0d", nv, res_parity, res_id, nv % 4);
                end
                nv++;
            end
            step();
        end
        req = '0;
        checks++; if (ng !== 5) begin failures++; $display("FAIL rr_count got=%0d exp=5", ng); end
        for (int i = 0; i < 5 && i < ng; i++) begin
            checks++;
            if (log_g[i] !== exp_g[i] || log_c[i] !== 10 * i) begin
                failures++; $display("FAIL rr_grant i=%0d gnt=%b cyc=%0d exp gnt=%b cyc=%0d", i, log_g[i], log_c[i], exp_g[i], 10 * i);
            end
        end
        for (int n = 0; n < 20 && busy === 1'b1; n++) step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rr_drain busy=%b exp=0", busy); end
    endtask

    task automatic test_odd_mode();
        logic [7:0] words [5] = '{8'h00, 8'hFF, 8'h01, 8'h03, 8'h80};
        logic       odds  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic       exps  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        res_ready = 1'b1;
        for (int v = 0; v < 5; v++) begin
            data[2*WIDTH +: WIDTH] = words[v];
            odd = '0; odd[2] = odds[v];
            req = 4'b0100;
            #1;
            for (int n = 0; n < 20 && gnt === 4'b0000; n++) step();
            checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL odd_gnt v=%0d got=%b exp=0100", v, gnt); end
            step();
            req = '0;
            for (int n = 0; n < 20 && res_valid !== 1'b1; n++) step();
            checks++;
            if (res_valid !== 1'b1 || res_parity !== exps[v] || res_id !== 2'd2) begin
                failures++; $display("FAIL odd_result v=%0d valid=%b par=%b id=%0d exp valid=1 par=%b id=2", v, res_valid, res_parity, res_id, exps[v]);
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        res_ready = 1'b0;
        data[7:0] = 8'h07; data[15:8] = 8'h03; odd = '0;
        req = 4'b0001;
        #1;
        for (int n = 0; n < 20 && gnt === 4'b0000; n++) step();
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL bp_gnt0 got=%b exp=0001", gnt); end
        step();
        req = 4'b0010;
        #1;
        for (int n = 0; n < 20 && res_valid !== 1'b1; n++) begin
            checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL bp_busy_gnt got=%b exp=0000", gnt); end
            step();
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (res_valid !== 1'b1 || res_parity !== 1'b1 || res_id !== 2'd0 || gnt !== 4'b0000) begin
                failures++; $display("FAIL bp_hold k=%0d valid=%b par=%b id=%0d gnt=%b exp 1 1 0 0000", k, res_valid, res_parity, res_id, gnt);
            end
            step();
        end
        res_ready = 1'b1;
        #1;
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL bp_accept_gnt got=%b exp=0000", gnt); end
        step();
        checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL bp_next_gnt got=%b exp=0010", gnt); end
        step();
        req = '0;
        for (int n = 0; n < 20 && res_valid !== 1'b1; n++) step();
        checks++;
        if (res_valid !== 1'b1 || res_parity !== 1'b0 || res_id !== 2'd1) begin
            failures++; $display("FAIL bp_second valid=%b par=%b id=%0d exp 1 0 1", res_valid, res_parity, res_id);
        end
        step();
    endtask

    task automatic test_reset_mid_shift();
        do_reset();
        res_ready = 1'b1;
        data[7:0] = 8'h55; data[31:24] = 8'h01; odd = '0;
        req = 4'b0001;
        #1;
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL rst_first_gnt got=%b exp=0001", gnt); end
        for (int k = 0; k < 4; k++) step();
        req = 4'b1001;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", res_valid); end
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL rst_next_gnt got=%b exp=0001", gnt); end
        step();
        req = '0;
        for (int n = 0; n < 20 && res_valid !== 1'b1; n++) step();
        checks++;
        if (res_valid !== 1'b1 || res_id !== 2'd0 || res_parity !== 1'b0) begin
            failures++; $display("FAIL rst_result valid=%b id=%0d par=%b exp 1 0 0", res_valid, res_id, res_parity);
        end
        step();
    endtask

    task automatic test_random();
        int         ptr_m = 3;
        int         w;
        logic [3:0] eg;
        logic [7:0] word;
        logic       ob;
        do_reset();
        for (int op = 0; op < 400; op++) begin
            req  = 4'($urandom_range(1, 15));
            data = $urandom;
            odd  = 4'($urandom);
            res_ready = 1'b0;
            #1;
            for (int n = 0; n < 30 && gnt === 4'b0000; n++) step();
            w    = rr_pick(req, ptr_m);
            eg   = 4'b0001 << w;
            word = data[w*WIDTH +: WIDTH];
            ob   = odd[w];
            checks++; if (gnt !== eg) begin failures++; $display("FAIL rand_gnt op=%0d req=%b got=%b exp=%b", op, req, gnt, eg); end
            step();
            data = $urandom;
            odd  = 4'($urandom);
            req  = 4'($urandom_range(1, 15));
            for (int n = 0; n < 20 && res_valid !== 1'b1; n++) step();
            for (int d = $urandom_range(0, 2); d > 0; d--) step();
            checks++;
            if (res_valid !== 1'b1 || res_parity !== (^word ^ ob) || res_id !== IDW'(w)) begin
                failures++; $display("FAIL rand_result op=%0d valid=%b par=%b id=%0d exp 1 %b %0d", op, res_valid, res_parity, res_id, ^word ^ ob, w);
            end
            res_ready = 1'b1;
            step();
            ptr_m = w;
        end
        req = '0;
        res_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_req();
        test_odd_mode();
        test_backpressure();
        test_reset_mid_shift();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
